// File: rtl/i2s_tx_serializer_if.sv
// ---------------------------------------------------------------------------
// i2s_tx_serializer_if
//   Sample-in / serial-out bundle of the I2S transmit serializer.
//
//   left_in, right_in : signed BITSIZE-bit samples from the mixer
//   lrclk             : word select, 0 = left slot, 1 = right slot
//   sdata             : serial audio data, MSB first
//   sample_strobe     : one-cycle pulse at frame start (samples latched)
//
//   modport master : the serializer (consumes samples, drives the I2S side)
//   modport slave  : the surrounding audio chain / codec side
// ---------------------------------------------------------------------------
interface i2s_tx_serializer_if #(
  parameter int BITSIZE = 16
);
  logic signed [BITSIZE-1:0] left_in;
  logic signed [BITSIZE-1:0] right_in;
  logic                      lrclk;
  logic                      sdata;
  logic                      sample_strobe;

  modport master (
    input  left_in,
    input  right_in,
    output lrclk,
    output sdata,
    output sample_strobe
  );

  modport slave (
    output left_in,
    output right_in,
    input  lrclk,
    input  sdata,
    input  sample_strobe
  );
endinterface

// File: rtl/i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// i2s_tx_serializer
//   Final stage of the audio chain. Produces a 64-bclk frame (32 per slot),
//   latches the mixer's left/right samples at frame start and shifts them
//   out MSB first. Default timing is standard I2S (data one bclk after the
//   lrclk edge); with I2S_TX_LEFT_JUSTIFIED_EN defined the data starts on the
//   lrclk edge itself (left-justified).
//
//   Ports
//     bclk   : bit clock, every flop on its rising edge
//     reset  : synchronous, active-high; aborts any frame in progress
//     bus    : i2s_tx_serializer_if.master (samples in, lrclk/sdata/strobe out)
//
//   Parameters
//     BITSIZE : sample width, 8..24
//
//   Macro
//     I2S_TX_LEFT_JUSTIFIED_EN : selects left-justified data placement
// ---------------------------------------------------------------------------
module i2s_tx_serializer #(
  parameter int BITSIZE = 16
) (
  input  logic                bclk,
  input  logic                reset,
  i2s_tx_serializer_if.master bus
);

  localparam logic [5:0] LP_BITS = 6'(BITSIZE);

  // Slot position of the first data bit relative to the lrclk edge.
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  localparam logic [5:0] LP_OFS = 6'd0;
`else
  localparam logic [5:0] LP_OFS = 6'd1;
`endif

  // Frame position and per-channel shadows (index 0 = left, 1 = right).
  logic [5:0]              r_cnt;
  logic [1:0][BITSIZE-1:0] r_shadow;
  logic                    r_lrclk;
  logic                    r_sdata;
  logic                    r_strobe;

  logic [5:0]              w_cnt_nxt;
  logic                    w_frame_start;
  logic [1:0][BITSIZE-1:0] w_shadow_nxt;
  logic                    w_slot;
  logic [5:0]              w_pos;
  logic [5:0]              w_rel;
  logic [BITSIZE-1:0]      w_word;
  logic                    w_in_word;
  logic                    w_bit;

  // Outputs are registered from the *next* position so that, in the cycle
  // where r_cnt == p, the pins already show the values for position p.
  assign w_cnt_nxt     = r_cnt + 6'd1;
  assign w_frame_start = (w_cnt_nxt == 6'd0);

  // The shadow that will be current at the next position. On the 63->0
  // step this is the fresh sample, which the left-justified mode needs at
  // p=0 before the shadow flop has been written.
  assign w_shadow_nxt  = w_frame_start ? {bus.right_in, bus.left_in} : r_shadow;

  assign w_slot  = w_cnt_nxt[5];
  assign w_pos   = {1'b0, w_cnt_nxt[4:0]};

  // Bit position within the word; wraps to a large value before the first
  // data bit, so a single compare covers both ends of the window.
  assign w_rel     = w_pos - LP_OFS;
  assign w_in_word = (w_rel < LP_BITS);
  assign w_word    = w_shadow_nxt[w_slot];

  // MSB-first select: word bit [BITSIZE-1-rel].
  always_comb begin
    w_bit = 1'b0;
    for (int i = 0; i < BITSIZE; i++) begin
      if (w_rel == 6'(BITSIZE - 1 - i)) w_bit = w_word[i];
    end
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      // cnt parked at 63 so the first released edge lands on frame start.
      r_cnt    <= 6'd63;
      r_shadow <= '0;
      r_lrclk  <= 1'b1;
      r_sdata  <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_lrclk  <= w_slot;
      r_sdata  <= w_in_word & w_bit;
      r_strobe <= w_frame_start;
    end
  end

  assign bus.lrclk         = r_lrclk;
  assign bus.sdata         = r_sdata;
  assign bus.sample_strobe = r_strobe;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
module tb_i2s_tx_serializer;

  localparam int B = 16;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  localparam int OFS = 0;
`else
  localparam int OFS = 1;
`endif

  logic bclk;
  logic reset;

  i2s_tx_serializer_if #(.BITSIZE(B)) bus ();

  i2s_tx_serializer #(.BITSIZE(B)) dut (
    .bclk  (bclk),
    .reset (reset),
    .bus   (bus)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  int errors = 0;
  int checks = 0;

  // Reference model state: frame position and samples latched this frame.
  int           m_p;
  logic [B-1:0] m_l, m_r;
  logic [B-1:0] drv_l, drv_r;
  bit           full_frame;

  // Words reassembled from sdata over the current / last complete frame.
  logic [B-1:0] word_l, word_r, frm_l, frm_r;

  int  strobes, rises, bad_rises;
  logic prev_lr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (p=%0d)", tag, obs, exp, m_p);
    end
  endtask

  // Expected sdata at frame position p, straight from the slot rules.
  function automatic logic exp_bit(input int p, input logic [B-1:0] l, input logic [B-1:0] r);
    int q;
    logic [B-1:0] w;
    q = (p < 32) ? p : p - 32;
    w = (p < 32) ? l : r;
    if (q >= OFS && q < OFS + B) return w[B-1-(q-OFS)];
    return 1'b0;
  endfunction

  task automatic tick();
    int q;
    bit rst;
    @(posedge bclk);
    rst = reset;
    if (rst) begin
      m_p = 63; m_l = '0; m_r = '0;
      full_frame = 0; word_l = '0; word_r = '0;
    end else begin
      m_p = (m_p + 1) % 64;
      if (m_p == 0) begin
        m_l = drv_l; m_r = drv_r; full_frame = 1;
      end
    end
    #1;
    chk("lrclk",  32'(bus.lrclk),         32'(rst ? 1'b1 : (m_p >= 32)));
    chk("strobe", 32'(bus.sample_strobe), 32'(!rst && m_p == 0));
    chk("sdata",  32'(bus.sdata),         32'(rst ? 1'b0 : exp_bit(m_p, m_l, m_r)));
    if (!rst) begin
      if (bus.sample_strobe) strobes++;
      if (bus.lrclk && !prev_lr) begin
        rises++;
        if (m_p != 32) bad_rises++;
      end
      q = (m_p < 32) ? m_p : m_p - 32;
      if (q >= OFS && q < OFS + B) begin
        if (m_p < 32) word_l[B-1-(q-OFS)] = bus.sdata;
        else          word_r[B-1-(q-OFS)] = bus.sdata;
      end
      if (m_p == 63) begin
        frm_l = word_l; frm_r = word_r;
        if (full_frame) begin
          chk("frame_left_word",  32'(frm_l), 32'(m_l));
          chk("frame_right_word", 32'(frm_r), 32'(m_r));
        end
        word_l = '0; word_r = '0;
      end
    end
    prev_lr = bus.lrclk;
  endtask

  task automatic run_to(input int target);
    int n = 0;
    do begin
      tick();
      n++;
    end while (m_p != target && n < 200);
    chk("run_to_timeout", 32'(m_p), 32'(target));
  endtask

  task automatic set_in(input logic [B-1:0] l, input logic [B-1:0] r);
    drv_l = l; drv_r = r;
    bus.left_in = l; bus.right_in = r;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, r0, b0, pchg;
    logic [B-1:0] nl, nr;
    reset = 1'b1;
    prev_lr = 1'b1;
    strobes = 0; rises = 0; bad_rises = 0;
    word_l = '0; word_r = '0; frm_l = '0; frm_r = '0;
    set_in('0, '0);

    // Reset held three cycles, then released.
    repeat (3) tick();
    reset = 1'b0;
    set_in(16'h1234, 16'hFEDC);
    tick();
    chk("first_strobe", 32'(bus.sample_strobe), 32'd1);
    chk("first_lrclk",  32'(bus.lrclk),         32'd0);
    run_to(63);
    chk("first_frame_left",  32'(frm_l), 32'h1234);
    chk("first_frame_right", 32'(frm_r), 32'hFEDC);

    // Sign/extreme pattern.
    set_in(16'h8001, 16'h7FFE);
    run_to(63);
    chk("pattern_left",  32'(frm_l), 32'h8001);
    chk("pattern_right", 32'(frm_r), 32'h7FFE);

    // Periodicity over four frames.
    s0 = strobes; r0 = rises; b0 = bad_rises;
    repeat (256) tick();
    chk("strobe_count_4f", 32'(strobes - s0), 32'd4);
    chk("lrclk_rises_4f",  32'(rises - r0),   32'd4);
    chk("lrclk_rise_pos",  32'(bad_rises - b0), 32'd0);

    // Hold-off: input change mid-frame only shows in the next frame.
    set_in(16'hAAAA, 16'h0F0F);
    run_to(0);
    run_to(10);
    set_in(16'h5555, 16'hF0F0);
    run_to(63);
    chk("holdoff_cur_left",  32'(frm_l), 32'hAAAA);
    chk("holdoff_cur_right", 32'(frm_r), 32'h0F0F);
    run_to(63);
    chk("holdoff_next_left",  32'(frm_l), 32'h5555);
    chk("holdoff_next_right", 32'(frm_r), 32'hF0F0);

    // Reset in the middle of the right slot.
    set_in(16'hFFFF, 16'hFFFF);
    run_to(0);
    run_to(40);
    reset = 1'b1;
    tick();
    chk("midreset_sdata", 32'(bus.sdata), 32'd0);
    chk("midreset_lrclk", 32'(bus.lrclk), 32'd1);
    tick();
    nl = B'($urandom); nr = B'($urandom);
    set_in(nl, nr);
    reset = 1'b0;
    tick();
    chk("restart_strobe", 32'(bus.sample_strobe), 32'd1);
    run_to(63);
    chk("restart_left",  32'(frm_l), 32'(nl));
    chk("restart_right", 32'(frm_r), 32'(nr));

    // Randomized frames with inputs changing at random positions.
    for (int f = 0; f < 8; f++) begin
      pchg = int'($urandom_range(1, 62));
      run_to(pchg);
      set_in(B'($urandom), B'($urandom));
      run_to(63);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
